// File: rtl/text_buffer_dumper.sv
// ============================================================================
//  Module   : text_buffer_dumper
//  Purpose  : Scans the glyph-index text buffer and streams the decoded
//             character codes, with optional CR/LF per row, to a byte sink.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module text_buffer_dumper #(
    parameter int COLS   = 20,
    parameter int ROWS   = 7,
    parameter bit EOL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] rd_r,
    output logic [5:0] rd_c,
    input  logic [7:0] rd_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_addr   = 3'd1;
    localparam logic [2:0] c_st_fetch  = 3'd2;
    localparam logic [2:0] c_st_send   = 3'd3;
    localparam logic [2:0] c_st_eol_cr = 3'd4;
    localparam logic [2:0] c_st_eol_lf = 3'd5;
    localparam logic [2:0] c_st_fin    = 3'd6;

    localparam logic [3:0] c_last_row = 4'(ROWS - 1);
    localparam logic [5:0] c_last_col = 6'(COLS - 1);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [3:0] r_row;
    logic [5:0] r_col;
    logic [7:0] r_char;
    logic [7:0] w_char;
    logic       w_xfer;
    logic       w_col_last;
    logic       w_row_last;
    logic       w_abort;

    assign w_xfer     = tx_valid & tx_ready;
    assign w_col_last = (r_col >= c_last_col);
    assign w_row_last = (r_row >= c_last_row);
    assign w_abort    = abort & (r_state != c_st_idle);
    assign rd_r       = r_row;
    assign rd_c       = r_col;

    // Inverse of the feeder's character-to-glyph map
    always_comb begin
        if (rd_data <= 8'd9) begin
            w_char = rd_data + 8'd48;
        end else if (rd_data <= 8'd35) begin
            w_char = rd_data + 8'd55;
        end else if (rd_data <= 8'd61) begin
            w_char = rd_data + 8'd61;
        end else if (rd_data <= 8'd129) begin
            w_char = rd_data + 8'd66;
        end else if (rd_data == 8'd255) begin
            w_char = 8'h20;
        end else begin
            w_char = 8'h3F;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:   if (start) w_next = c_st_addr;
                c_st_addr:   w_next = c_st_fetch;
                c_st_fetch:  w_next = c_st_send;
                c_st_send: begin
                    if (w_xfer) begin
                        if (!w_col_last)     w_next = c_st_addr;
                        else if (EOL_EN)     w_next = c_st_eol_cr;
                        else if (!w_row_last) w_next = c_st_addr;
                        else                 w_next = c_st_fin;
                    end
                end
                c_st_eol_cr: if (w_xfer) w_next = c_st_eol_lf;
                c_st_eol_lf: if (w_xfer) w_next = w_row_last ? c_st_fin : c_st_addr;
                c_st_fin:    w_next = c_st_idle;
                default:     w_next = c_st_idle;
            endcase
        end
    end

    // Address walk and decoded-character holding register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_row  <= 4'd0;
            r_col  <= 6'd0;
            r_char <= 8'd0;
        end else if (w_abort) begin
            r_row <= 4'd0;
            r_col <= 6'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_row <= 4'd0;
                        r_col <= 6'd0;
                    end
                end
                c_st_fetch: r_char <= w_char;
                c_st_send: begin
                    if (w_xfer) begin
                        if (!w_col_last) begin
                            r_col <= r_col + 6'd1;
                        end else if (!EOL_EN && !w_row_last) begin
                            r_col <= 6'd0;
                            r_row <= r_row + 4'd1;
                        end
                    end
                end
                c_st_eol_lf: begin
                    if (w_xfer && !w_row_last) begin
                        r_col <= 6'd0;
                        r_row <= r_row + 4'd1;
                    end
                end
                c_st_fin: begin
                    r_row <= 4'd0;
                    r_col <= 6'd0;
                end
                default: ;
            endcase
        end
    end

    // FIN reports completion: done pulses while busy has already dropped
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = r_char;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            c_st_idle:   busy = 1'b0;
            c_st_send:   tx_valid = 1'b1;
            c_st_eol_cr: begin
                tx_valid = 1'b1;
                tx_data  = 8'h0D;
            end
            c_st_eol_lf: begin
                tx_valid = 1'b1;
                tx_data  = 8'h0A;
            end
            c_st_fin: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_text_buffer_dumper.sv
// ============================================================================
//  Module   : tb_text_buffer_dumper
//  Purpose  : Self-checking bench; two dumpers (EOL on / EOL off) share one
//             buffer image and are compared against a byte-queue model.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_text_buffer_dumper;

    localparam int COLS = 20;
    localparam int ROWS = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset    = 1'b0;
    logic start    = 1'b0;
    logic abort    = 1'b0;
    logic tx_ready = 1'b0;

    logic [3:0] rd_r     [2];
    logic [5:0] rd_c     [2];
    logic [7:0] rd_data  [2];
    logic [7:0] tx_data  [2];
    logic       tx_valid [2];
    logic       busy     [2];
    logic       done     [2];

    logic [7:0] mem [0:ROWS-1][0:COLS-1];
    logic [7:0] tbl [0:255];

    int total = 0;
    int bad   = 0;

    text_buffer_dumper #(.COLS(COLS), .ROWS(ROWS), .EOL_EN(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rd_r(rd_r[0]), .rd_c(rd_c[0]), .rd_data(rd_data[0]),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready),
        .busy(busy[0]), .done(done[0])
    );

    text_buffer_dumper #(.COLS(COLS), .ROWS(ROWS), .EOL_EN(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rd_r(rd_r[1]), .rd_c(rd_c[1]), .rd_data(rd_data[1]),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready),
        .busy(busy[1]), .done(done[1])
    );

    // Buffer spare read port: one-cycle read latency
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rd_r[k] < ROWS && rd_c[k] < COLS) rd_data[k] <= mem[rd_r[k]][rd_c[k]];
            else rd_data[k] <= 8'hFF;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: expected byte stream per instance, entry = {is_cell, row, col, byte}
    logic [18:0] exq   [2][0:159];
    int          head  [2] = '{0, 0};
    int          tail  [2] = '{0, 0};
    bit          act   [2] = '{0, 0};
    bit          fin   [2] = '{0, 0};
    bit          rstk  [2] = '{0, 0};
    bit          rdz   [2] = '{0, 0};
    bit          allrdy[2] = '{0, 0};
    bit          pstall[2] = '{0, 0};
    logic [7:0]  pdata [2];
    int          cyc   [2] = '{0, 0};
    int          nbytes[2] = '{0, 0};
    logic [18:0] m_e;
    bit          m_xfer;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (act[k]) begin
                check("busy_active", 32'(busy[k]), 1);
                check("done_active", 32'(done[k]), 0);
                if (cyc[k] == 1) begin
                    check("first_row", 32'(rd_r[k]), 0);
                    check("first_col", 32'(rd_c[k]), 0);
                end
                if (pstall[k]) begin
                    check("stall_valid", 32'(tx_valid[k]), 1);
                    check("stall_data", 32'(tx_data[k]), 32'(pdata[k]));
                end
                if (tx_valid[k] === 1'b1) begin
                    check("byte_expected", 32'(tail[k] > head[k]), 1);
                    if (tail[k] > head[k]) begin
                        m_e = exq[k][head[k]];
                        check("tx_data", 32'(tx_data[k]), 32'(m_e[7:0]));
                        if (m_e[18]) begin
                            check("rd_r", 32'(rd_r[k]), 32'(m_e[17:14]));
                            check("rd_c", 32'(rd_c[k]), 32'(m_e[13:8]));
                        end
                    end
                end
            end else if (fin[k]) begin
                check("done_pulse", 32'(done[k]), 1);
                check("busy_fin", 32'(busy[k]), 0);
                check("valid_fin", 32'(tx_valid[k]), 0);
                check("byte_count", 32'(nbytes[k]), (k == 0) ? 154 : 140);
                if (allrdy[k]) check("dump_cycles", 32'(cyc[k]), (k == 0) ? 435 : 421);
            end else begin
                check("idle_busy", 32'(busy[k]), 0);
                check("idle_done", 32'(done[k]), 0);
                check("idle_valid", 32'(tx_valid[k]), 0);
                if (rstk[k]) check("reset_tx_data", 32'(tx_data[k]), 0);
                if (rdz[k]) begin
                    check("idle_row", 32'(rd_r[k]), 0);
                    check("idle_col", 32'(rd_c[k]), 0);
                end
            end

            if (reset !== 1'b1) begin
                act[k] = 0; fin[k] = 0; rstk[k] = 1; rdz[k] = 1;
                head[k] = 0; tail[k] = 0; pstall[k] = 0;
            end else if (fin[k]) begin
                fin[k] = 0; rdz[k] = 1;
            end else if (act[k]) begin
                m_xfer    = (tx_valid[k] === 1'b1) && tx_ready;
                pstall[k] = (tx_valid[k] === 1'b1) && !tx_ready;
                pdata[k]  = tx_data[k];
                if (!tx_ready) allrdy[k] = 0;
                if (m_xfer) begin head[k]++; nbytes[k]++; end
                cyc[k]++;
                if (abort) begin
                    act[k] = 0; rdz[k] = 0; pstall[k] = 0;
                end else if (m_xfer && head[k] >= tail[k]) begin
                    act[k] = 0; fin[k] = 1;
                end
            end else if (start) begin
                head[k] = 0; tail[k] = 0;
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        exq[k][tail[k]] = {1'b1, 4'(r), 6'(c), tbl[mem[r][c]]};
                        tail[k]++;
                    end
                    if (k == 0) begin
                        exq[k][tail[k]] = {1'b0, 4'(r), 6'(COLS-1), 8'h0D}; tail[k]++;
                        exq[k][tail[k]] = {1'b0, 4'(r), 6'(COLS-1), 8'h0A}; tail[k]++;
                    end
                end
                act[k] = 1; cyc[k] = 1; nbytes[k] = 0; allrdy[k] = 1;
                rstk[k] = 0; pstall[k] = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill(input int v, input bit rnd);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mem[r][c] = rnd ? 8'($urandom_range(0, 255)) : 8'(v);
    endtask

    task automatic wait_idle(input int maxc, input bit rnd);
        int n = 0;
        while ((act[0] || fin[0] || act[1] || fin[1]) && n < maxc) begin
            if (rnd) tx_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        check("dump_finished", 32'(act[0] || fin[0] || act[1] || fin[1]), 0);
        tx_ready = 1'b1;
        tick();
    endtask

    // Waits for a DUT0 condition selected by mode; 0: row 3 reached, 1: CR offered, 2: cell (2,7) offered
    task automatic wait_for(input int mode, input int maxc);
        int  n = 0;
        bit  hit = 0;
        while (!hit && n < maxc) begin
            tick();
            n++;
            case (mode)
                0: hit = (rd_r[0] == 4'd3);
                1: hit = tx_valid[0] && (tx_data[0] == 8'h0D);
                default: hit = tx_valid[0] && (rd_r[0] == 4'd2) && (rd_c[0] == 6'd7);
            endcase
        end
        check("wait_condition", 32'(hit), 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tbl[i] = 8'h3F;
        tbl[255] = 8'h20;
        for (int ch = 0; ch < 256; ch++) begin
            if (ch >= 48 && ch <= 57)        tbl[ch - 48] = 8'(ch);
            else if (ch >= 65 && ch <= 90)   tbl[ch - 55] = 8'(ch);
            else if (ch >= 97 && ch <= 122)  tbl[ch - 61] = 8'(ch);
            else if (ch >= 128 && ch <= 195) tbl[ch - 66] = 8'(ch);
        end
        check("pin_g0",   32'(tbl[0]),   8'h30);
        check("pin_g10",  32'(tbl[10]),  8'h41);
        check("pin_g36",  32'(tbl[36]),  8'h61);
        check("pin_g62",  32'(tbl[62]),  8'h80);
        check("pin_g128", 32'(tbl[128]), 8'hC2);
        check("pin_g129", 32'(tbl[129]), 8'hC3);
        check("pin_g130", 32'(tbl[130]), 8'h3F);
        check("pin_g200", 32'(tbl[200]), 8'h3F);
        check("pin_g254", 32'(tbl[254]), 8'h3F);
        check("pin_g255", 32'(tbl[255]), 8'h20);
        check("pin_g5",   32'(tbl[5]),   8'h35);

        fill(255, 0);
        tick(); tick();
        reset = 1'b1;
        tick(); tick();

        // Mixed-range first row, cleared cells elsewhere
        mem[0][0] = 8'd0; mem[0][1] = 8'd10; mem[0][2] = 8'd36;
        mem[0][3] = 8'd62; mem[0][4] = 8'd129;
        tx_ready = 1'b1;
        pulse_start();
        wait_idle(3000, 0);

        // Out-of-range glyphs and the unknown marker
        fill(255, 0);
        mem[1][0] = 8'd130; mem[1][1] = 8'd200; mem[2][5] = 8'd254; mem[6][19] = 8'd128;
        pulse_start();
        wait_idle(3000, 0);

        // Ten-cycle stall mid-row, with a start pulse that must be ignored
        fill(0, 1);
        pulse_start();
        wait_for(2, 1000);
        tx_ready = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        tx_ready = 1'b1;
        wait_idle(3000, 0);

        // Whole screen of glyph 5
        fill(5, 0);
        pulse_start();
        wait_idle(3000, 0);

        // Abort during row 3, then a fresh dump from the origin
        fill(0, 1);
        pulse_start();
        wait_for(0, 1000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        pulse_start();
        wait_idle(3000, 0);

        // One-cycle reset while CR is offered and stalled
        pulse_start();
        wait_for(1, 1000);
        tx_ready = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tx_ready = 1'b1;
        tick(); tick();

        // Random buffers and random backpressure
        for (int t = 0; t < 4; t++) begin
            fill(0, 1);
            pulse_start();
            wait_idle(5000, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
